// File: rtl/spr_dma.sv
// Sprite-RAM DMA writer: copies LEN bytes of CPU work RAM starting at
// SRC_BASE into the four-bank sprite RAM (bank = byte address[1:0],
// row = byte address[8:2]). Each byte takes one RD and one WR step, and the
// FSM only steps on cycles with ce=1.
module spr_dma #(
    parameter logic [15:0] SRC_BASE = 16'h0600,
    parameter int          LEN      = 512,
    parameter bit          WAIT_VB  = 1'b1
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        ce,
    input  logic        vb,
    input  logic        start,
    input  logic        abort,
    output logic [15:0] src_addr,
    input  logic [7:0]  src_data,
    output logic [8:0]  dst_addr,
    output logic [7:0]  dst_data,
    output logic        dst_we,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {IDLE, ARM, RD, WR} state_t;

    localparam logic [8:0] LAST_CNT = 9'(LEN - 1);

    state_t     r_state;
    state_t     w_state_next;
    logic [8:0] r_cnt;
    logic [8:0] w_cnt_next;
    logic       r_done;
    logic       w_done_next;
    logic [8:0] r_dst_addr;
    logic [7:0] r_dst_data;
    logic       w_we;
    logic       w_last;

    // The work RAM has a registered read: the address shown during RD is
    // captured on the RD->WR edge, so src_data is valid throughout WR.
    // Deriving src_addr from cnt keeps it stable in WR even when ce stalls.
    assign src_addr = SRC_BASE + {7'd0, r_cnt};
    assign w_last   = (r_cnt == LAST_CNT);

    // The write strobe is combinational so it can never appear outside WR or
    // on a ce=0 cycle, and abort kills it in the very cycle it is raised.
    assign w_we     = (r_state == WR) && ce && !abort;
    assign dst_we   = w_we;
    assign dst_addr = w_we ? r_cnt    : r_dst_addr;
    assign dst_data = w_we ? src_data : r_dst_data;
    assign busy     = (r_state != IDLE);
    assign done     = r_done;

    // Next-state, counter and completion-pulse logic; abort overrides all.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_done_next  = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_next = ARM;
                    w_cnt_next   = 9'd0;
                end
            end
            ARM: begin
                if (ce && (vb || !WAIT_VB)) begin
                    w_state_next = RD;
                end
            end
            RD: begin
                if (ce) begin
                    w_state_next = WR;
                end
            end
            WR: begin
                if (ce) begin
                    if (w_last) begin
                        w_state_next = IDLE;
                        w_done_next  = 1'b1;
                    end else begin
                        w_cnt_next   = r_cnt + 9'd1;
                        w_state_next = RD;
                    end
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
        if (abort) begin
            w_state_next = IDLE;
            w_cnt_next   = r_cnt;
            w_done_next  = 1'b0;
        end
    end

    // State register, byte counter and done pulse.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_cnt   <= 9'd0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_done  <= w_done_next;
        end
    end

    // Remember the last written address/data so the sprite-RAM bus holds
    // steady between strobes.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_dst_addr <= 9'd0;
            r_dst_data <= 8'd0;
        end else if (w_we) begin
            r_dst_addr <= r_cnt;
            r_dst_data <= src_data;
        end
    end

endmodule

// File: tb/tb_spr_dma.sv
// Testbench for spr_dma: per-cycle vector table for the short corner cases,
// plus hand-written sequences for full copies, vblank gating, pacing, abort
// and asynchronous reset. Work RAM holds byte (addr - 0x0600) ^ 0x5A.
module tb_spr_dma;

    logic        clk_sys;
    logic        reset_n;
    logic        ce;
    logic        vb;
    logic        start;
    logic        abort;
    logic [15:0] src_addr;
    logic [7:0]  src_data;
    logic [8:0]  dst_addr;
    logic [7:0]  dst_data;
    logic        dst_we;
    logic        busy;
    logic        done;

    int vec_cnt = 0;
    int err_cnt = 0;

    spr_dma #(
        .SRC_BASE (16'h0600),
        .LEN      (512),
        .WAIT_VB  (1'b1)
    ) u_dut (
        .clk_sys  (clk_sys),
        .reset_n  (reset_n),
        .ce       (ce),
        .vb       (vb),
        .start    (start),
        .abort    (abort),
        .src_addr (src_addr),
        .src_data (src_data),
        .dst_addr (dst_addr),
        .dst_data (dst_data),
        .dst_we   (dst_we),
        .busy     (busy),
        .done     (done)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    // Work RAM with a registered read port.
    always @(posedge clk_sys) begin
        src_data <= 8'(src_addr - 16'h0600) ^ 8'h5A;
    end

    typedef struct {
        logic [3:0]  in;     // {ce, vb, start, abort}
        logic [2:0]  flags;  // {busy, dst_we, done}
        logic [8:0]  daddr;
        logic [7:0]  ddata;
        logic [15:0] saddr;
    } vec_t;

    vec_t tbl [19];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    // Full transfer from IDLE with vb=1; caller is at a negedge. ce is high
    // on every period-th cycle. If restart_at >= 0, a second start is issued
    // while the restart_at-th byte is in flight.
    task automatic run_full(input int period, input int restart_at, input string tag);
        int writes   = 0;
        int dones    = 0;
        int last_we  = -1;
        int done_cyc = -1;
        int bad      = 0;
        int post     = 0;
        bit restarted = 1'b0;
        for (int cyc = 0; cyc < 8000; cyc++) begin
            vb    = 1'b1;
            abort = 1'b0;
            ce    = ((cyc % period) == 0);
            start = (cyc == 0) ||
                    (restart_at >= 0 && !restarted && cyc > 0 && writes == restart_at - 1);
            if (start && cyc > 0) restarted = 1'b1;
            #1;
            if (dst_we === 1'b1) begin
                if (dst_addr !== 9'(writes) || dst_data !== (8'(writes) ^ 8'h5A) || ce !== 1'b1)
                    bad++;
                writes++;
                last_we = cyc;
            end
            if (done === 1'b1) begin
                dones++;
                if (done_cyc < 0) done_cyc = cyc;
                if (busy !== 1'b0) bad++;
            end else if (cyc > 0 && dones == 0 && busy !== 1'b1) begin
                bad++;
            end
            @(negedge clk_sys);
            if (dones > 0) post++;
            if (post > 4) break;
        end
        start = 1'b0;
        chk({tag, " writes"}, writes, 512);
        chk({tag, " done_count"}, dones, 1);
        chk({tag, " done_after_last_we"}, done_cyc, last_we + 1);
        // start at cycle 0, ARM at 1, RD entry at 2, then 2*LEN cycles to the last write
        if (period == 1) chk({tag, " last_we_cycle"}, last_we, 1025);
        chk({tag, " order_data_busy_errors"}, bad, 0);
    endtask

    // Start with vb low for 100 cycles, then raise vb for one cycle.
    task automatic run_vblank();
        int bad = 0;
        int first = -1;
        logic [15:0] sa0 = 16'h0;
        ce = 1'b1; vb = 1'b0; start = 1'b1; abort = 1'b0;
        #1;
        @(negedge clk_sys);
        start = 1'b0;
        for (int i = 0; i < 100; i++) begin
            ce = 1'b1; vb = 1'b0;
            #1;
            if (i == 0) sa0 = src_addr;
            if (busy !== 1'b1 || dst_we !== 1'b0 || src_addr !== sa0) bad++;
            @(negedge clk_sys);
        end
        chk("vb_gate_errors", bad, 0);
        chk("vb_arm_src_addr", sa0, 16'h0600);
        for (int k = 0; k < 10; k++) begin
            ce = 1'b1;
            vb = (k == 0);
            #1;
            if (dst_we === 1'b1 && first < 0) first = k;
            @(negedge clk_sys);
            if (first >= 0) break;
        end
        chk("vb_first_we_delay", first, 2);
        abort = 1'b1;
        #1;
        @(negedge clk_sys);
        abort = 1'b0;
        #1;
        chk("vb_abort_idle_busy", busy, 0);
        @(negedge clk_sys);
    endtask

    // Abort right after the 10th write, then retrigger.
    task automatic run_abort();
        int writes = 0;
        int bad = 0;
        int first_addr = -1;
        for (int cyc = 0; cyc < 100 && writes < 10; cyc++) begin
            ce = 1'b1; vb = 1'b1; start = (cyc == 0); abort = 1'b0;
            #1;
            if (dst_we === 1'b1) writes++;
            @(negedge clk_sys);
        end
        start = 1'b0;
        chk("abort_writes_before", writes, 10);
        abort = 1'b1;
        #1;
        @(negedge clk_sys);
        abort = 1'b0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (dst_we !== 1'b0 || done !== 1'b0 || busy !== 1'b0) bad++;
            @(negedge clk_sys);
        end
        chk("abort_quiet_errors", bad, 0);
        for (int cyc = 0; cyc < 20; cyc++) begin
            start = (cyc == 0);
            #1;
            if (dst_we === 1'b1 && first_addr < 0) first_addr = int'(dst_addr);
            @(negedge clk_sys);
            if (first_addr >= 0) break;
        end
        start = 1'b0;
        chk("abort_restart_addr", first_addr, 0);
        abort = 1'b1;
        #1;
        @(negedge clk_sys);
        abort = 1'b0;
    endtask

    // Asynchronous reset in the middle of a WR cycle, then a fresh transfer.
    task automatic run_reset();
        bit found = 1'b0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            ce = 1'b1; vb = 1'b1; start = (cyc == 0); abort = 1'b0;
            #1;
            if (dst_we === 1'b1) begin
                found = 1'b1;
                break;
            end
            @(negedge clk_sys);
        end
        start = 1'b0;
        chk("rst_reached_wr", found, 1);
        #1;
        reset_n = 1'b0;
        #1;
        chk("rst_async_we", dst_we, 0);
        chk("rst_async_busy", busy, 0);
        chk("rst_async_dst_addr", dst_addr, 0);
        chk("rst_async_done", done, 0);
        @(negedge clk_sys);
        @(negedge clk_sys);
        reset_n = 1'b1;
        run_full(1, -1, "post_reset");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{4'b1000, 3'b000, 9'd0, 8'h00, 16'h0600};
        tbl[1]  = '{4'b0010, 3'b000, 9'd0, 8'h00, 16'h0600};
        tbl[2]  = '{4'b1000, 3'b100, 9'd0, 8'h00, 16'h0600};
        tbl[3]  = '{4'b1010, 3'b100, 9'd0, 8'h00, 16'h0600};
        tbl[4]  = '{4'b0100, 3'b100, 9'd0, 8'h00, 16'h0600};
        tbl[5]  = '{4'b1100, 3'b100, 9'd0, 8'h00, 16'h0600};
        tbl[6]  = '{4'b1000, 3'b100, 9'd0, 8'h00, 16'h0600};
        tbl[7]  = '{4'b1000, 3'b110, 9'd0, 8'h5A, 16'h0600};
        tbl[8]  = '{4'b1000, 3'b100, 9'd0, 8'h5A, 16'h0601};
        tbl[9]  = '{4'b0000, 3'b100, 9'd0, 8'h5A, 16'h0601};
        tbl[10] = '{4'b1000, 3'b110, 9'd1, 8'h5B, 16'h0601};
        tbl[11] = '{4'b1000, 3'b100, 9'd1, 8'h5B, 16'h0602};
        tbl[12] = '{4'b1001, 3'b100, 9'd1, 8'h5B, 16'h0602};
        tbl[13] = '{4'b1010, 3'b000, 9'd1, 8'h5B, 16'h0602};
        tbl[14] = '{4'b1100, 3'b100, 9'd1, 8'h5B, 16'h0600};
        tbl[15] = '{4'b1100, 3'b100, 9'd1, 8'h5B, 16'h0600};
        tbl[16] = '{4'b1111, 3'b100, 9'd1, 8'h5B, 16'h0600};
        tbl[17] = '{4'b1111, 3'b000, 9'd1, 8'h5B, 16'h0600};
        tbl[18] = '{4'b1100, 3'b000, 9'd1, 8'h5B, 16'h0600};

        reset_n = 1'b0; ce = 1'b0; vb = 1'b0; start = 1'b0; abort = 1'b0;
        repeat (2) @(negedge clk_sys);
        #1;
        chk("reset_busy", busy, 0);
        chk("reset_we", dst_we, 0);
        chk("reset_done", done, 0);
        chk("reset_dst_addr", dst_addr, 0);
        chk("reset_dst_data", dst_data, 0);
        chk("reset_src_addr", src_addr, 16'h0600);
        @(negedge clk_sys);
        reset_n = 1'b1;

        for (int i = 0; i < 19; i++) begin
            @(negedge clk_sys);
            {ce, vb, start, abort} = tbl[i].in;
            #1;
            chk($sformatf("v%0d busy", i), busy, tbl[i].flags[2]);
            chk($sformatf("v%0d we", i), dst_we, tbl[i].flags[1]);
            chk($sformatf("v%0d done", i), done, tbl[i].flags[0]);
            chk($sformatf("v%0d dst_addr", i), dst_addr, tbl[i].daddr);
            chk($sformatf("v%0d dst_data", i), dst_data, tbl[i].ddata);
            chk($sformatf("v%0d src_addr", i), src_addr, tbl[i].saddr);
        end
        @(negedge clk_sys);
        {ce, vb, start, abort} = 4'b0000;
        @(negedge clk_sys);

        run_full(1, 200, "full_copy");
        run_full(3, -1, "paced");
        run_vblank();
        run_abort();
        run_reset();

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
